uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmit holding register (8-bit TXREG + TXIF empty flag) among NREQ byte requesters (CPU, DMA, debug).
//  Round-robin arbitration, grant locked for a burst, one write per byte gated by TXIF.
//  Sits between the requesters and the TXREG write port: drives its write_enable/data_in and reads its TXIF.
// PARAMETERS
//  NREQ       4     number of requesters (2..8)
//  DW         8     byte width carried per write
//  BURST_MAX  16    max bytes per grant before forced release (1..255)
//  BLANK_CYC  2     cycles TXIF is ignored after each write (TXIF falls 1 cycle late)
//  TIMEOUT    1024  cycles in GRANT with TXIF low before timeout (macro only)
// PORTS
//  clk          in   1         clock, rising edge
//  rst          in   1         reset, synchronous, active-high
//  req          in   NREQ      per-requester byte-valid, held until ack
//  req_data     in   NREQ*DW   requester i byte at [i*DW +: DW]
//  req_last     in   NREQ      byte is last of burst; qualified by req
//  ack          out  NREQ      1-cycle pulse: byte of requester i written
//  gnt          out  NREQ      one-hot current owner, 0 when idle
//  gnt_id       out  3         index of owner, valid when busy
//  busy         out  1         grant held
//  txif         in   1         holding register empty (1 = may write)
//  txreg_we     out  1         1-cycle write strobe to holding register
//  txreg_data   out  DW        byte to holding register, valid with txreg_we
//  timeout_err  out  1         sticky timeout flag (UART_ARB_TIMEOUT_EN)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer = NREQ-1 (requester 0 highest), byte count 0, blank count 0.
//  All outputs registered. States IDLE, GRANT, BLANK.
//  IDLE: any req -> pick first set req after rr pointer (wrapping, modulo NREQ);
//   next cycle gnt/gnt_id/busy set, -> GRANT. No req -> stay.
//  GRANT: if req[g] & txif -> txreg_we=1, txreg_data=req_data[g], ack[g]=1 same cycle, byte count +1, -> BLANK.
//   If req[g]=0 at a GRANT cycle -> release: gnt=0, busy=0, rr pointer=g, -> IDLE.
//  BLANK: hold BLANK_CYC cycles ignoring txif, no writes. Then:
//   - accepted byte had req_last=1 or byte count==BURST_MAX -> release (as above), count=0.
//   - else -> GRANT (same owner keeps lock).
//  Release cycle never re-grants; new arbitration decided in IDLE next cycle (min 1 idle cycle between owners).
//  Latency: req in IDLE -> gnt +1 cycle -> first txreg_we +1 cycle (if txif=1).
//  Simultaneous req: round-robin; released owner lowest priority next arbitration.
//  Non-owner req ignored, never acked; req_data only sampled for owner.
//  Back-to-back bytes: 1 + BLANK_CYC cycles minimum per byte.
//  txreg_we never asserted twice within BLANK_CYC+1 cycles; never with txif=0.
//  Byte count width 8 bits; wraps never (forced release at BURST_MAX).
//  Reset mid-burst: immediate return to reset state; in-flight byte not acked unless ack already pulsed.
// CONFIGURATION
//  UART_ARB_TIMEOUT_EN defined: counter runs in GRANT while req[g]=1 & txif=0; reset on any write/leave GRANT.
//   At TIMEOUT cycles: timeout_err<=1 (sticky until rst), grant released, rr pointer=g, -> IDLE.
//  Not defined: no counter, timeout_err tied 0, GRANT waits on txif indefinitely.
// TESTING
//  T1 single: txif=1, req=0001, data0=8'hA5, last=1 -> gnt=0001 at +1, txreg_we/data=A5/ack[0] at +2, busy=0 after BLANK.
//  T2 burst lock: req=0011, req0 3 bytes last on 3rd -> 3 writes of req0 spaced 3 cycles, then gnt=0010.
//  T3 round-robin: req=1111 all last=1 -> grant order 0,1,2,3,0; each one byte.
//  T4 BURST_MAX=16: req0 never last, 20 bytes -> release after 16th ack, req1 (pending) granted next.
//  T5 txif stall: txif=0 for 50 cycles in GRANT -> no txreg_we; txif=1 -> write next cycle; rst mid-stall -> all outputs 0.
//  T6 timeout (macro, TIMEOUT=1024): txif=0 held -> timeout_err=1 at 1024 cycles, busy=0, flag sticky until rst.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester and TX holding-register signals shared through the UART TX arbiter.
interface uart_tx_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    ack;
    logic [NREQ-1:0]    gnt;
    logic [2:0]         gnt_id;
    logic               busy;
    logic               txif;
    logic               txreg_we;
    logic [DW-1:0]      txreg_data;

    modport master (
        output req, req_data, req_last, txif,
        input  ack, gnt, gnt_id, busy, txreg_we, txreg_data
    );

    modport slave (
        input  req, req_data, req_last, txif,
        output ack, gnt, gnt_id, busy, txreg_we, txreg_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX holding register among NREQ byte requesters.
// Defining UART_ARB_TIMEOUT_EN adds a sticky stall timeout that releases a stuck grant.
module uart_tx_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DW        = 8,
    parameter int unsigned BURST_MAX = 16,
    parameter int unsigned BLANK_CYC = 2,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus,
    output logic             timeout_err
);
    typedef enum logic [1:0] {StIdle, StGrant, StBlank} state_e;

    localparam int unsigned BlankW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

    state_e            state;
    logic [2:0]        rr_ptr;
    logic [7:0]        byte_cnt;
    logic [BlankW-1:0] blank_cnt;
    logic              last_byte;

    logic [NREQ-1:0]   gnt_q;
    logic [2:0]        gnt_id_q;
    logic              busy_q;
    logic [NREQ-1:0]   ack_q;
    logic              we_q;
    logic [DW-1:0]     data_q;

    logic              owner_req;
    logic              owner_last;
    logic [DW-1:0]     owner_data;
    logic              arb_found;
    logic [2:0]        arb_idx;
    logic              blank_done;
    logic              timeout_hit;
    logic              release_now;

    assign owner_req  = |(bus.req & gnt_q);
    assign owner_last = |(bus.req_last & gnt_q);

    always_comb begin
        owner_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) owner_data = bus.req_data[i*DW +: DW];
        end
    end

    // Smallest requester above rr_ptr wins; otherwise wrap to the smallest one at or below it.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (bus.req[i] && i <= int'(rr_ptr)) begin
                arb_found = 1'b1;
                arb_idx   = 3'(i);
            end
        end
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (bus.req[i] && i > int'(rr_ptr)) begin
                arb_found = 1'b1;
                arb_idx   = 3'(i);
            end
        end
    end

    assign blank_done  = (blank_cnt == BlankW'(BLANK_CYC - 1));
    assign release_now = ((state == StGrant) && !owner_req) || timeout_hit ||
                         ((state == StBlank) && blank_done &&
                          (last_byte || byte_cnt == 8'(BURST_MAX)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            rr_ptr    <= 3'(NREQ - 1);
            byte_cnt  <= '0;
            blank_cnt <= '0;
            last_byte <= 1'b0;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
            ack_q     <= '0;
            we_q      <= 1'b0;
            data_q    <= '0;
        end else begin
            ack_q <= '0;
            we_q  <= 1'b0;
            if (release_now) begin
                // Released owner becomes lowest priority; arbitration waits one idle cycle.
                state     <= StIdle;
                rr_ptr    <= gnt_id_q;
                byte_cnt  <= '0;
                blank_cnt <= '0;
                gnt_q     <= '0;
                gnt_id_q  <= '0;
                busy_q    <= 1'b0;
            end else begin
                case (state)
                    StIdle: begin
                        if (arb_found) begin
                            gnt_q    <= NREQ'(1) << arb_idx;
                            gnt_id_q <= arb_idx;
                            busy_q   <= 1'b1;
                            state    <= StGrant;
                        end
                    end
                    StGrant: begin
                        if (bus.txif) begin
                            we_q      <= 1'b1;
                            data_q    <= owner_data;
                            ack_q     <= gnt_q;
                            byte_cnt  <= byte_cnt + 8'd1;
                            last_byte <= owner_last;
                            blank_cnt <= '0;
                            state     <= StBlank;
                        end
                    end
                    StBlank: begin
                        if (blank_done) state <= StGrant;
                        else blank_cnt <= blank_cnt + 1'b1;
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned TimeoutW = $clog2(TIMEOUT + 1);

    logic [TimeoutW-1:0] to_cnt;
    logic                stalled;
    logic                err_q;

    assign stalled     = (state == StGrant) && owner_req && !bus.txif;
    assign timeout_hit = stalled && (to_cnt == TimeoutW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (!stalled || timeout_hit) to_cnt <= '0;
            else to_cnt <= to_cnt + 1'b1;
            if (timeout_hit) err_q <= 1'b1;
        end
    end

    assign timeout_err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign bus.gnt        = gnt_q;
    assign bus.gnt_id     = gnt_id_q;
    assign bus.busy       = busy_q;
    assign bus.ack        = ack_q;
    assign bus.txreg_we   = we_q;
    assign bus.txreg_data = data_q;

    // Write-port safety: single owner, consistent busy, writes separated by the blank window.
    assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
    assert property (@(posedge clk) disable iff (rst) busy_q == (gnt_q != '0));
    assert property (@(posedge clk) disable iff (rst) we_q |=> !we_q);
    assert property (@(posedge clk) disable iff (rst) we_q |-> $onehot(ack_q));
endmodule
